// File: rtl/constant_sink_checker.sv
// -----------------------------------------------------------------------------
// constant_sink_checker
//
// Purpose:
//   Tail-end receiver for a constant token generator. Consumes tokens on a
//   valid/ready channel, counts accepted tokens and checks every accepted data
//   word against a fixed expected constant. It can throttle the producer with
//   a fixed number of stall cycles after each accept, and it can close the
//   channel after a given number of tokens.
//
// Handshake:
//   A token transfers on a rising clk edge where ins_valid && ins_ready.
//   ins_ready depends only on registered state, never on ins_valid. A
//   producer that sees ins_valid high with ins_ready low must hold its token.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   clr            in   synchronous clear of count, flags and state (active high)
//   ins            in   [DATA_WIDTH-1:0] incoming token data
//   ins_valid      in   incoming token valid
//   ins_ready      out  sink ready (high only in ACCEPT)
//   token_count    out  [CNT_WIDTH-1:0] accepted tokens since reset/clr, saturating
//   mismatch       out  sticky: some accepted token differed from EXPECTED
//   mismatch_data  out  [DATA_WIDTH-1:0] data of the first mismatching token
//   done           out  high while in DONE (token limit reached)
//   dbg_state      out  [1:0] current FSM state (ACCEPT/STALL/DONE encoding below)
// -----------------------------------------------------------------------------
module constant_sink_checker #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned EXPECTED     = 1,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned TOKEN_LIMIT  = 0,
    parameter int unsigned STALL_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [CNT_WIDTH-1:0]  token_count,
    output logic                  mismatch,
    output logic [DATA_WIDTH-1:0] mismatch_data,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    // FSM encoding
    localparam logic [1:0] S_ACCEPT = 2'b00;
    localparam logic [1:0] S_STALL  = 2'b01;
    localparam logic [1:0] S_DONE   = 2'b10;

    // Stall counter is wide enough to hold STALL_CYCLES; keep at least 1 bit
    // so the register exists even when stalling is disabled.
    localparam int unsigned STALL_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

    localparam logic [DATA_WIDTH-1:0] EXP_C   = DATA_WIDTH'(EXPECTED);
    localparam logic [CNT_WIDTH-1:0]  LIMIT_C = CNT_WIDTH'(TOKEN_LIMIT);
    localparam logic [STALL_W-1:0]    STALL_C = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0]    STALL_1 = STALL_W'(1);

    localparam bit LIMIT_EN = (TOKEN_LIMIT != 0);
    localparam bit STALL_EN = (STALL_CYCLES != 0);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [1:0]            state_q,    state_d;
    logic [STALL_W-1:0]    stall_q,    stall_d;
    logic [CNT_WIDTH-1:0]  count_q,    count_d;
    logic                  mismatch_q, mismatch_d;
    logic [DATA_WIDTH-1:0] mdata_q,    mdata_d;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic                 ready;
    logic                 xfer;
    logic                 cnt_sat;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign ready   = (state_q == S_ACCEPT);
    assign xfer    = ins_valid && ready;
    assign cnt_sat = &count_q;
    // Saturating increment: once all-ones the count sticks there.
    assign cnt_inc = cnt_sat ? count_q : count_q + CNT_WIDTH'(1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        mdata_d    = mdata_q;

        if (clr) begin
            // Clear wins over a same-cycle transfer: that token is dropped
            // without being counted or checked.
            state_d    = S_ACCEPT;
            stall_d    = '0;
            count_d    = '0;
            mismatch_d = 1'b0;
            mdata_d    = '0;
        end else begin
            case (state_q)
                S_ACCEPT: begin
                    if (xfer) begin
                        count_d = cnt_inc;
                        // Only the first bad token is captured.
                        if ((ins != EXP_C) && !mismatch_q) begin
                            mismatch_d = 1'b1;
                            mdata_d    = ins;
                        end
                        // Reaching the limit closes the channel immediately,
                        // skipping any stall that would otherwise follow.
                        if (LIMIT_EN && (cnt_inc == LIMIT_C)) begin
                            state_d = S_DONE;
                        end else if (STALL_EN) begin
                            state_d = S_STALL;
                            stall_d = STALL_C;
                        end
                    end
                end

                S_STALL: begin
                    // Counter is loaded with STALL_CYCLES and leaves at 1,
                    // giving exactly STALL_CYCLES ready-low cycles.
                    if (stall_q <= STALL_1) begin
                        state_d = S_ACCEPT;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q - STALL_1;
                    end
                end

                S_DONE: begin
                    state_d = S_DONE;
                end

                default: begin
                    state_d = S_ACCEPT;
                    stall_d = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_ACCEPT;
            stall_q    <= '0;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            mdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            mdata_q    <= mdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all from registered state)
    // -------------------------------------------------------------------------
    assign ins_ready     = ready;
    assign token_count   = count_q;
    assign mismatch      = mismatch_q;
    assign mismatch_data = mdata_q;
    assign done          = (state_q == S_DONE);
    assign dbg_state     = state_q;

endmodule
